ds_dac_modulator: RTL and testbench
===================================

// Module: ds_dac_modulator
// PURPOSE
//  First-order delta-sigma modulator. It is the transmit-side counterpart of the ds_adc model.
//  It accepts signed PCM samples at the base rate and emits a 1-bit oversampled bitstream.
//  The density of 1s in each frame tracks the sample value: 1 = +FS, 0 = -FS.
//  Synthesizable; feeds an analog reconstruction filter or ds_adc for loopback checks.
// PARAMETERS
//  WIDTH           8    sample width (signed, two's complement); FS = 2**(WIDTH-1)
//  OVERSAMP_RATIO  256  clk cycles per sample frame; power of 2, >= 2
// PORTS
//  clk          in   1      oversampling clock; all state on posedge
//  rstn         in   1      asynchronous active-low reset
//  din          in   WIDTH  signed sample, full range -FS..FS-1
//  din_valid    in   1      din offered
//  din_ready    out  1      1-entry input buffer empty; transfer = din_valid & din_ready
//  bit_out      out  1      modulator bitstream, registered
//  frame_start  out  1      1-cycle pulse: a new frame began (cur sample (re)loaded)
//  underrun     out  1      1-cycle pulse: frame boundary reached with the buffer empty
// BEHAVIOUR
//  Reset (async, rstn=0): the following are cleared.
//   - integ=0, cur=0, buf_full=0, frame_cnt=0
//   - bit_out=0, frame_start=0, underrun=0
//   - din_ready=1 during and after reset
//  Input buffer:
//   - din_ready = !buf_full (from a register only; no combinational path from din_valid).
//   - On transfer, buf <= din and buf_full <= 1.
//   - No transfer can coincide with a buffer drain, because ready=0 while the buffer is full.
//  Frame counter:
//   - frame_cnt increments every clk and wraps OVERSAMP_RATIO-1 -> 0.
//   - Boundary = the cycle where frame_cnt==OVERSAMP_RATIO-1.
//  At the boundary:
//   - If buf_full: cur <= buf, buf_full <= 0.
//   - Else: cur holds its previous value and underrun=1 the next cycle.
//   - frame_start=1 the next cycle (frame_cnt==0) in both cases.
//  Modulator, every clk:
//   - fb = bit_out ? +FS : -FS
//   - v  = integ + cur - fb, signed WIDTH+2 bits, no saturation
//   - integ <= v; bit_out <= (v >= 0)
//  Range:
//   - |cur| <= FS keeps integ within [-2FS, 2FS), so WIDTH+2 bits never overflow.
//   - Overflow must be impossible; an assertion checks it.
//  Transfer function: in steady state, the 1s per frame = OVERSAMP_RATIO/2 + din*OVERSAMP_RATIO/(2*FS), +/-1.
//  Latency:
//   - A sample accepted in any cycle of frame k becomes cur at the start of frame k+1.
//   - If it arrives after frame k's boundary, it waits for the next boundary.
//   - The first bit influenced by the new cur appears one cycle after frame_start.
//  Idle (cur=0): bitstream averages 0.5. From reset the sequence is 1,1,0,1,0,1,...
//  Extremes:
//   - din=-FS: integ stays constant and bit_out is all 0 once settled.
//   - din=FS-1: at most 1 zero per frame.
//  Reset mid-frame: all state is abandoned immediately. Any buffered sample is discarded.
//   The counter restarts at 0, and no frame_start/underrun pulse occurs for the partial frame.
// TESTING (WIDTH=8, OVERSAMP_RATIO=256, FS=128)
//  1 Reset, no input:
//    - frame_start every 256 clk; underrun pulses with each frame_start.
//    - 1s per frame = 128 +/-1; first bits after reset are 1,1,0,1.
//  2 din=+64, then din=-64, then din=0, one per frame:
//    - 1s counted in the frame after each frame_start are 192, 64, 128 (+/-1).
//    - No underrun while fed.
//  3 din=127 and din=-128 each held several frames:
//    - 1s per frame >= 254, then == 0 after the first settled frame.
//    - The integ overflow assertion never fires.
//  4 Handshake, din_valid held high with a new din after each transfer:
//    - din_ready drops the cycle after a transfer and returns 1 cycle after the boundary.
//    - Exactly one transfer per frame; no sample is lost or duplicated (scoreboard on cur).
//  5 Reset asserted at frame_cnt=100 with buf_full=1:
//    - bit_out=0, din_ready=1, and frame_cnt=0 immediately.
//    - The buffered sample never reaches cur; the next frame_start is 256 clk after release.
//  6 Loopback, bit_out -> ds_adc-style counter over a 256-cycle frame:
//    - 5 random din in -128..127.
//    - Reconverted (ones-128)/128 matches din/128 within 1.001*2/256; print PASS/FAIL.

Source files
------------

// File: rtl/ds_dac_modulator.sv
// First-order delta-sigma DAC modulator: one-entry sample buffer, frame counter that
// reloads the current sample at each frame boundary, and a 1-bit integrating loop.
module ds_dac_modulator #(
   parameter int WIDTH          = 8,
   parameter int OVERSAMP_RATIO = 256
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [WIDTH-1:0] din,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic                    bit_out,
   output logic                    frame_start,
   output logic                    underrun
);

   localparam int CW = $clog2(OVERSAMP_RATIO);
   localparam int IW = WIDTH + 2;

   localparam logic [CW-1:0]        CNT_LAST = CW'(OVERSAMP_RATIO - 1);
   localparam logic signed [IW-1:0] FB_POS   = IW'(2 ** (WIDTH - 1));
   localparam logic signed [IW-1:0] FB_NEG   = -FB_POS;
   localparam logic signed [IW:0]   V_MAX    = (IW + 1)'(2 ** WIDTH);
   localparam logic signed [IW:0]   V_MIN    = -V_MAX;

   logic [CW-1:0]        frame_cnt_q, frame_cnt_d;
   logic signed [WIDTH-1:0] sample_buf_q, sample_buf_d;
   logic                 buf_full_q, buf_full_d;
   logic signed [WIDTH-1:0] cur_q, cur_d;
   logic signed [IW-1:0] integ_q, integ_d;
   logic                 bit_q, bit_d;
   logic                 frame_start_q, frame_start_d;
   logic                 underrun_q, underrun_d;

   logic                 boundary;
   logic                 xfer;
   logic signed [IW-1:0] fb;
   logic signed [IW:0]   v_wide;

   always_comb begin
      boundary    = (frame_cnt_q == CNT_LAST);
      xfer        = din_valid & ~buf_full_q;
      frame_cnt_d = frame_cnt_q + CW'(1);

      sample_buf_d = sample_buf_q;
      buf_full_d   = buf_full_q;
      cur_d        = cur_q;
      if (xfer) begin
         sample_buf_d = din;
         buf_full_d   = 1'b1;
      end
      // ready is low while full, so a load and a drain never land in the same cycle
      if (boundary && buf_full_q) begin
         cur_d      = sample_buf_q;
         buf_full_d = 1'b0;
      end

      frame_start_d = boundary;
      underrun_d    = boundary & ~buf_full_q;
   end

   // Loop sum is formed one bit wider so the range assertion sees a true overflow.
   always_comb begin
      fb      = bit_q ? FB_POS : FB_NEG;
      v_wide  = (IW + 1)'(integ_q) + (IW + 1)'(cur_q) - (IW + 1)'(fb);
      integ_d = v_wide[IW-1:0];
      bit_d   = ~v_wide[IW];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_cnt_q   <= '0;
         sample_buf_q  <= '0;
         buf_full_q    <= 1'b0;
         cur_q         <= '0;
         integ_q       <= '0;
         bit_q         <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         sample_buf_q  <= sample_buf_d;
         buf_full_q    <= buf_full_d;
         cur_q         <= cur_d;
         integ_q       <= integ_d;
         bit_q         <= bit_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign din_ready   = ~buf_full_q;
   assign bit_out     = bit_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

   a_integ_range: assert property (@(posedge clk) disable iff (!rstn)
      (v_wide >= V_MIN) && (v_wide < V_MAX));

endmodule

// File: tb/tb_ds_dac_modulator.sv
// Directed bench for ds_dac_modulator: frame timing, density per frame, handshake,
// mid-frame reset and a loopback ones-count reconversion.
module tb_ds_dac_modulator;

   localparam int WIDTH = 8;
   localparam int OSR   = 256;
   localparam int FS    = 128;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic signed [WIDTH-1:0] din;
   logic                    din_valid;
   logic                    din_ready;
   logic                    bit_out;
   logic                    frame_start;
   logic                    underrun;

   int n_err = 0;
   int n_chk = 0;

   ds_dac_modulator #(.WIDTH(WIDTH), .OVERSAMP_RATIO(OSR)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .bit_out     (bit_out),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
      n_chk++;
      if (obs > exp + tol || obs < exp - tol) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Runs exactly one frame starting at frame_cnt==0, optionally offering one sample.
   task automatic run_frame(input bit feed, input int d, output int ones, output int fs_n,
                            output int fs_at, output int ur_n, output int first4);
      bit rdy, vld;
      ones = 0; fs_n = 0; fs_at = 0; ur_n = 0; first4 = 0;
      din       = 8'(d);
      din_valid = feed;
      for (int c = 1; c <= OSR; c++) begin
         rdy = din_ready;
         vld = din_valid;
         @(posedge clk); #1;
         if (vld && rdy) din_valid = 1'b0;
         ones += int'(bit_out);
         if (frame_start) begin
            fs_n++;
            fs_at = c;
         end
         ur_n += int'(underrun);
         if (c <= 4) first4 = (first4 << 1) | int'(bit_out);
      end
   endtask

   task automatic frame_chk(input string tag, input bit feed, input int d, input int exp_ur,
                            output int ones, output int first4);
      int fs_n, fs_at, ur_n;
      run_frame(feed, d, ones, fs_n, fs_at, ur_n, first4);
      chk({tag, "_fs_cnt"}, fs_n, 1);
      chk({tag, "_fs_pos"}, fs_at, OSR);
      chk({tag, "_underrun"}, ur_n, exp_ur);
   endtask

   initial begin
      int ones, f4, n, xf;
      bit found;
      int q[$];
      int vals[4];
      int d;

      vals = '{10, -20, 30, -40};
      rstn = 1'b0; din = '0; din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bit_out", int'(bit_out), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_din_ready", int'(din_ready), 1);
      chk("rst_frame_cnt", int'(dut.frame_cnt_q), 0);
      rstn = 1'b1;

      // idle from reset: 1,1,0,1 then alternating
      frame_chk("t1a", 1'b0, 0, 1, ones, f4);
      chk("t1_first_bits", f4, 4'b1101);
      chk("t1a_ones", ones, 128, 1);
      frame_chk("t1b", 1'b0, 0, 1, ones, f4);
      chk("t1b_ones", ones, 128, 1);

      frame_chk("t2a", 1'b1, 64, 0, ones, f4);
      chk("t2a_ones", ones, 128, 1);
      frame_chk("t2b", 1'b1, -64, 0, ones, f4);
      chk("t2b_ones", ones, 192, 1);
      frame_chk("t2c", 1'b1, 0, 0, ones, f4);
      chk("t2c_ones", ones, 64, 1);
      frame_chk("t2d", 1'b0, 0, 1, ones, f4);
      chk("t2d_ones", ones, 128, 1);

      frame_chk("t3a", 1'b1, 127, 0, ones, f4);
      chk("t3a_ones", ones, 128, 1);
      frame_chk("t3b", 1'b1, 127, 0, ones, f4);
      chk("t3b_ones", ones, 255, 1);
      frame_chk("t3c", 1'b1, -128, 0, ones, f4);
      chk("t3c_ones", ones, 255, 1);
      frame_chk("t3d", 1'b1, -128, 0, ones, f4);
      chk("t3d_ones", ones, 0, 1);
      frame_chk("t3e", 1'b0, 0, 1, ones, f4);
      chk("t3e_ones", ones, 0);

      // handshake with din_valid held high, scoreboard against cur
      n = 0; xf = 0;
      din = 8'(vals[0]); din_valid = 1'b1;
      for (int c = 1; c <= 3 * OSR; c++) begin
         bit rdy, vld;
         rdy = din_ready;
         vld = din_valid;
         @(posedge clk); #1;
         if (vld && rdy) begin
            q.push_back(int'(din));
            xf++;
            chk("t4_ready_drop", int'(din_ready), 0);
            n++;
            din = 8'(vals[n % 4]);
         end
         if (frame_start) begin
            chk("t4_ready_back", int'(din_ready), 1);
            chk("t4_xfer_per_frame", xf, 1);
            xf = 0;
            if (q.size() == 0) chk("t4_sb_empty", 0, 1);
            else chk("t4_cur", int'(dut.cur_q), q.pop_front());
         end
      end
      din_valid = 1'b0;
      chk("t4_sb_left", q.size(), 0);
      chk("t4_transfers", n, 3);

      // reset at frame_cnt=100 with a sample buffered
      din = 8'(99); din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      chk("t5_cnt_pre", int'(dut.frame_cnt_q), 100);
      chk("t5_full_pre", int'(din_ready), 0);
      rstn = 1'b0;
      #1;
      chk("t5_bit_out", int'(bit_out), 0);
      chk("t5_din_ready", int'(din_ready), 1);
      chk("t5_frame_cnt", int'(dut.frame_cnt_q), 0);
      chk("t5_no_fs", int'(frame_start), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1'b1;
      n = 0; found = 1'b0;
      while (!found && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (frame_start) found = 1'b1;
      end
      chk("t5_fs_delay", n, OSR);
      chk("t5_cur_cleared", int'(dut.cur_q), 0);
      chk("t5_underrun", int'(underrun), 1);

      // loopback: ones-count reconversion of a settled frame
      for (int i = 0; i < 5; i++) begin
         d = int'($urandom_range(255)) - FS;
         frame_chk("t6_load", 1'b1, d, 0, ones, f4);
         frame_chk("t6_settle", 1'b0, 0, 1, ones, f4);
         frame_chk("t6_meas", 1'b0, 0, 1, ones, f4);
         chk("t6_loopback", ones - FS, d, 1);
         if (ones - FS - d <= 1 && ones - FS - d >= -1)
            $display("loopback din=%0d ones=%0d PASS", d, ones);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
